// File: rtl/cache_line_transfer_engine_pkg.sv
// Shared types for the cache line transfer engine: FSM states, default geometry and the AXI beat record.
// Pure declarations; no timing or flow-control behaviour lives here.
package cache_line_transfer_engine_pkg;

   localparam int TOTAL_WIDTH  = 32;
   localparam int OFFSET_WIDTH = 4;
   localparam int WORDS        = 2 ** (OFFSET_WIDTH - 2);
   localparam int BEAT_W       = OFFSET_WIDTH - 2;

   typedef enum logic [2:0] {
      IDLE,
      WB_REQ,
      WB_WAIT,
      RD_REQ,
      RD_WAIT,
      DONE
   } xfer_state_t;

   // One single-word memory transaction as presented on the axi_* port.
   typedef struct packed {
      logic                   we;
      logic [TOTAL_WIDTH-1:0] addr;
      logic [TOTAL_WIDTH-1:0] data;
   } axi_beat_t;

endpackage

// File: rtl/cache_line_transfer_engine_if.sv
// Cache-side request/response and memory-side beat signals of the line transfer engine.
// slave = the engine, master = the cache controller plus memory port that drive it.
interface cache_line_transfer_engine_if #(
   parameter int total_width = cache_line_transfer_engine_pkg::TOTAL_WIDTH,
   parameter int words       = cache_line_transfer_engine_pkg::WORDS
);
   logic                         req_i;
   logic [total_width-1:0]       req_addr_i;
   logic                         evict_i;
   logic [total_width-1:0]       evict_addr_i;
   logic [words*total_width-1:0] evict_line_i;
   logic                         busy_o;
   logic                         done_o;
   logic                         err_o;
   logic [words*total_width-1:0] fill_line_o;
   logic                         axi_start_o;
   logic                         axi_we_o;
   logic [total_width-1:0]       axi_address_o;
   logic [total_width-1:0]       axi_data_o;
   logic                         axi_rdy_i;
   logic [total_width-1:0]       axi_data_i;

   modport slave (
      input  req_i, req_addr_i, evict_i, evict_addr_i, evict_line_i, axi_rdy_i, axi_data_i,
      output busy_o, done_o, err_o, fill_line_o, axi_start_o, axi_we_o, axi_address_o, axi_data_o
   );

   modport master (
      output req_i, req_addr_i, evict_i, evict_addr_i, evict_line_i, axi_rdy_i, axi_data_i,
      input  busy_o, done_o, err_o, fill_line_o, axi_start_o, axi_we_o, axi_address_o, axi_data_o
   );
endinterface

// File: rtl/cache_line_transfer_engine_timeout_ctr.sv
// Per-beat wait counter: cleared while a beat is being issued, counts wait cycles while enabled.
// expired_o flags the wait cycle that brings the count to TIMEOUT-1; no backpressure.
module xfer_timeout_ctr #(
   parameter int TIMEOUT = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 2));
endmodule

// File: rtl/cache_line_transfer_engine.sv
// Miss engine: optional victim write-back, then a critical-word-first refill, one word beat at a time.
// Each beat is a 1-cycle axi_start_o and a wait for axi_rdy_i (2 cycles minimum), bounded by TIMEOUT.
module cache_line_transfer_engine
   import cache_line_transfer_engine_pkg::*;
#(
   parameter int total_width  = TOTAL_WIDTH,
   parameter int offset_width = OFFSET_WIDTH,
   parameter bit CRIT_FIRST   = 1'b1,
   parameter int TIMEOUT      = 64
) (
   input logic                         clk_i,
   input logic                         rst_i,
   cache_line_transfer_engine_if.slave bus
);
   localparam int W  = 2 ** (offset_width - 2);
   localparam int BW = offset_width - 2;
   localparam int LW = total_width - offset_width;

   xfer_state_t              state_q;
   logic [LW-1:0]            req_line_q;
   logic [LW-1:0]            evict_line_q;
   logic [W*total_width-1:0] evict_data_q;
   logic [W*total_width-1:0] fill_q;
   logic [BW-1:0]            crit_q;
   logic [BW-1:0]            wb_idx_q;
   logic [BW-1:0]            rd_idx_q;
   logic [BW-1:0]            rd_cnt_q;
   logic [BW-1:0]            wb_nxt;
   logic [BW-1:0]            rd_nxt;
   logic [BW-1:0]            start_word;
   axi_beat_t                beat_q;
   logic                     axi_start_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     err_q;
   logic                     tmo_clr;
   logic                     tmo_en;
   logic                     tmo_exp;

   function automatic axi_beat_t mk_beat(input logic we, input logic [LW-1:0] line,
                                         input logic [BW-1:0] idx,
                                         input logic [total_width-1:0] data);
      return '{we: we, addr: {line, idx, 2'b00}, data: data};
   endfunction

   assign wb_nxt     = wb_idx_q + 1'b1;
   assign rd_nxt     = rd_idx_q + 1'b1;
   assign start_word = CRIT_FIRST ? bus.req_addr_i[offset_width-1:2] : '0;
   assign tmo_clr    = (state_q == WB_REQ) || (state_q == RD_REQ);
   assign tmo_en     = (state_q == WB_WAIT) || (state_q == RD_WAIT);

   xfer_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (tmo_clr),
      .en_i     (tmo_en),
      .expired_o(tmo_exp)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         req_line_q   <= '0;
         evict_line_q <= '0;
         evict_data_q <= '0;
         fill_q       <= '0;
         crit_q       <= '0;
         wb_idx_q     <= '0;
         rd_idx_q     <= '0;
         rd_cnt_q     <= '0;
         beat_q       <= '0;
         axi_start_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         axi_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_i) begin
                  busy_q       <= 1'b1;
                  err_q        <= 1'b0;
                  axi_start_q  <= 1'b1;
                  req_line_q   <= bus.req_addr_i[total_width-1:offset_width];
                  evict_line_q <= bus.evict_addr_i[total_width-1:offset_width];
                  evict_data_q <= bus.evict_line_i;
                  crit_q       <= start_word;
                  wb_idx_q     <= '0;
                  rd_idx_q     <= start_word;
                  rd_cnt_q     <= '0;
                  if (bus.evict_i) begin
                     state_q <= WB_REQ;
                     beat_q  <= mk_beat(1'b1, bus.evict_addr_i[total_width-1:offset_width], '0,
                                        bus.evict_line_i[total_width-1:0]);
                  end else begin
                     state_q <= RD_REQ;
                     beat_q  <= mk_beat(1'b0, bus.req_addr_i[total_width-1:offset_width],
                                        start_word, '0);
                  end
               end
            end
            WB_REQ: state_q <= WB_WAIT;
            WB_WAIT: begin
               // A late rdy still wins over the timeout in the same cycle.
               if (bus.axi_rdy_i) begin
                  axi_start_q <= 1'b1;
                  if (wb_idx_q == BW'(W - 1)) begin
                     state_q <= RD_REQ;
                     beat_q  <= mk_beat(1'b0, req_line_q, crit_q, '0);
                  end else begin
                     state_q  <= WB_REQ;
                     wb_idx_q <= wb_nxt;
                     beat_q   <= mk_beat(1'b1, evict_line_q, wb_nxt,
                                         evict_data_q[wb_nxt*total_width +: total_width]);
                  end
               end else if (tmo_exp) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end
            end
            RD_REQ: state_q <= RD_WAIT;
            RD_WAIT: begin
               if (bus.axi_rdy_i) begin
                  fill_q[rd_idx_q*total_width +: total_width] <= bus.axi_data_i;
                  rd_idx_q <= rd_nxt;
                  if (rd_cnt_q == BW'(W - 1)) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= RD_REQ;
                     rd_cnt_q    <= rd_cnt_q + 1'b1;
                     axi_start_q <= 1'b1;
                     beat_q      <= mk_beat(1'b0, req_line_q, rd_nxt, '0);
                  end
               end else if (tmo_exp) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy_o        = busy_q;
   assign bus.done_o        = done_q;
   assign bus.err_o         = err_q;
   assign bus.fill_line_o   = fill_q;
   assign bus.axi_start_o   = axi_start_q;
   assign bus.axi_we_o      = beat_q.we;
   assign bus.axi_address_o = beat_q.addr;
   assign bus.axi_data_o    = beat_q.data;
endmodule

// File: tb/tb_cache_line_transfer_engine.sv
// Directed bench for the line transfer engine with a delay-programmable word memory model.
module tb_cache_line_transfer_engine;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   cache_line_transfer_engine_if #(.total_width(32), .words(4)) bus ();

   cache_line_transfer_engine #(
      .total_width(32), .offset_width(4), .CRIT_FIRST(1'b1), .TIMEOUT(64)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [127:0] exp_line(input logic [31:0] base);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = mem_rd(base + 32'(4 * i));
      return l;
   endfunction

   // Memory model: sees axi_start_o at the negedge of the REQ cycle, answers after `delay` wait cycles.
   int          delay = 0;
   int          hang_at = -1;
   bit          spur = 1'b0;
   bit          hang = 1'b0;
   bit          pend = 1'b0;
   int          wcnt = 0;
   logic [31:0] cur_addr = '0;
   logic [31:0] log_addr[64];
   logic [31:0] log_data[64];
   logic        log_we[64];
   int          log_cyc[64];
   int          log_n = 0;

   always @(negedge clk_i) begin
      if (rst_i) begin
         pend = 1'b0;
         hang = 1'b0;
         bus.axi_rdy_i = 1'b0;
         bus.axi_data_i = '0;
      end else begin
         bus.axi_rdy_i = spur && !pend;
         if (pend && !hang) begin
            if (wcnt == 0) begin
               bus.axi_rdy_i = 1'b1;
               bus.axi_data_i = mem_rd(cur_addr);
               pend = 1'b0;
            end else begin
               wcnt--;
            end
         end
         if (bus.axi_start_o) begin
            if (log_n < 64) begin
               log_addr[log_n] = bus.axi_address_o;
               log_data[log_n] = bus.axi_data_o;
               log_we[log_n]   = bus.axi_we_o;
               log_cyc[log_n]  = cyc;
            end
            cur_addr = bus.axi_address_o;
            pend = 1'b1;
            wcnt = delay;
            hang = (log_n == hang_at);
            log_n++;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_req(input logic [31:0] a, input logic ev, input logic [31:0] ea,
                            input logic [127:0] el, output int rc);
      bus.req_i = 1'b1;
      bus.req_addr_i = a;
      bus.evict_i = ev;
      bus.evict_addr_i = ea;
      bus.evict_line_i = el;
      rc = cyc;
      @(negedge clk_i);
      bus.req_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int dc);
      bit seen = 1'b0;
      dc = -1;
      for (int i = 0; i < 500; i++) begin
         if (bus.done_o) begin
            seen = 1'b1;
            dc = cyc;
            break;
         end
         @(negedge clk_i);
      end
      chk(tag, 128'(seen), 128'd1);
   endtask

   initial begin
      int rc, dc, base;
      logic [127:0] eline;
      bus.req_i = 1'b0;
      bus.req_addr_i = '0;
      bus.evict_i = 1'b0;
      bus.evict_addr_i = '0;
      bus.evict_line_i = '0;
      repeat (3) @(negedge clk_i);
      chk("rst_busy", 128'(bus.busy_o), 128'd0);
      chk("rst_done", 128'(bus.done_o), 128'd0);
      chk("rst_err", 128'(bus.err_o), 128'd0);
      chk("rst_start", 128'(bus.axi_start_o), 128'd0);
      chk("rst_we", 128'(bus.axi_we_o), 128'd0);
      chk("rst_addr", 128'(bus.axi_address_o), 128'd0);
      chk("rst_data", 128'(bus.axi_data_o), 128'd0);
      chk("rst_fill", bus.fill_line_o, 128'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // 1: critical-word-first read, immediate rdy; req cycle and done cycle both counted.
      base = log_n;
      start_req(32'h0000_1238, 1'b0, '0, '0, rc);
      wait_done("t1_done", dc);
      chk("t1_latency", 128'(dc - rc + 1), 128'd10);
      chk("t1_nbeats", 128'(log_n - base), 128'd4);
      chk("t1_a0", 128'(log_addr[base]), 128'h1238);
      chk("t1_a1", 128'(log_addr[base+1]), 128'h123C);
      chk("t1_a2", 128'(log_addr[base+2]), 128'h1230);
      chk("t1_a3", 128'(log_addr[base+3]), 128'h1234);
      chk("t1_we", 128'({log_we[base], log_we[base+1], log_we[base+2], log_we[base+3]}), 128'd0);
      chk("t1_fill", bus.fill_line_o, exp_line(32'h1230));
      chk("t1_busy_at_done", 128'(bus.busy_o), 128'd0);
      @(negedge clk_i);

      // 2: write-back of victim {D,C,B,A} then refill of 0x8000.
      eline = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      base = log_n;
      start_req(32'h0000_8000, 1'b1, 32'h0000_4000, eline, rc);
      wait_done("t2_done", dc);
      chk("t2_nbeats", 128'(log_n - base), 128'd8);
      for (int i = 0; i < 4; i++) begin
         chk("t2_wr_addr", 128'(log_addr[base+i]), 128'(32'h4000 + 32'(4 * i)));
         chk("t2_wr_we", 128'(log_we[base+i]), 128'd1);
         chk("t2_wr_data", 128'(log_data[base+i]), 128'(eline[i*32 +: 32]));
         chk("t2_rd_addr", 128'(log_addr[base+4+i]), 128'(32'h8000 + 32'(4 * i)));
         chk("t2_rd_we", 128'(log_we[base+4+i]), 128'd0);
      end
      chk("t2_err", 128'(bus.err_o), 128'd0);
      chk("t2_fill", bus.fill_line_o, exp_line(32'h8000));
      @(negedge clk_i);

      // 3: third beat never answered -> abort 64 cycles after its axi_start_o.
      base = log_n;
      hang_at = base + 2;
      start_req(32'h0000_2004, 1'b0, '0, '0, rc);
      wait_done("t3_done", dc);
      chk("t3_tmo_cycles", 128'(dc - log_cyc[base+2]), 128'd64);
      chk("t3_err_at_done", 128'(bus.err_o), 128'd1);
      chk("t3_nbeats", 128'(log_n - base), 128'd3);
      @(negedge clk_i);
      chk("t3_err_held", 128'(bus.err_o), 128'd1);
      hang_at = -1;
      base = log_n;
      start_req(32'h0000_3000, 1'b0, '0, '0, rc);
      chk("t3_err_cleared", 128'(bus.err_o), 128'd0);
      wait_done("t3b_done", dc);
      chk("t3b_fill", bus.fill_line_o, exp_line(32'h3000));
      @(negedge clk_i);

      // 4: rdy held high outside wait cycles, 2-cycle memory delay -> 4 cycles per beat.
      spur = 1'b1;
      delay = 2;
      repeat (2) @(negedge clk_i);
      chk("t4_idle_busy", 128'(bus.busy_o), 128'd0);
      base = log_n;
      start_req(32'h0000_5008, 1'b0, '0, '0, rc);
      wait_done("t4_done", dc);
      chk("t4_latency", 128'(dc - rc), 128'd17);
      chk("t4_nbeats", 128'(log_n - base), 128'd4);
      chk("t4_a0", 128'(log_addr[base]), 128'h5008);
      chk("t4_a3", 128'(log_addr[base+3]), 128'h5004);
      chk("t4_fill", bus.fill_line_o, exp_line(32'h5000));
      spur = 1'b0;
      delay = 0;
      @(negedge clk_i);

      // 5: async reset during the REQ cycle of refill beat 1.
      base = log_n;
      start_req(32'h0000_6004, 1'b0, '0, '0, rc);
      for (int i = 0; i < 100; i++) begin
         if (log_n >= base + 2) break;
         @(negedge clk_i);
         #1;
      end
      chk("t5_reached_beat1", 128'(log_n - base), 128'd2);
      #1 rst_i = 1'b1;
      #1;
      chk("t5_busy", 128'(bus.busy_o), 128'd0);
      chk("t5_start", 128'(bus.axi_start_o), 128'd0);
      chk("t5_addr", 128'(bus.axi_address_o), 128'd0);
      chk("t5_fill", bus.fill_line_o, 128'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      base = log_n;
      repeat (5) @(negedge clk_i);
      chk("t5_no_reissue", 128'(log_n - base), 128'd0);
      start_req(32'h0000_7000, 1'b0, '0, '0, rc);
      wait_done("t5b_done", dc);
      chk("t5b_nbeats", 128'(log_n - base), 128'd4);
      chk("t5b_fill", bus.fill_line_o, exp_line(32'h7000));
      @(negedge clk_i);

      // 6: req held through the transfer -> one transfer, then back-to-back acceptance.
      base = log_n;
      bus.req_i = 1'b1;
      bus.req_addr_i = 32'h0000_9000;
      bus.evict_i = 1'b0;
      @(negedge clk_i);
      wait_done("t6_done", dc);
      chk("t6_single", 128'(log_n - base), 128'd4);
      @(negedge clk_i);
      chk("t6_idle_gap", 128'(bus.busy_o), 128'd0);
      @(negedge clk_i);
      chk("t6_b2b_busy", 128'(bus.busy_o), 128'd1);
      chk("t6_b2b_start", 128'(bus.axi_start_o), 128'd1);
      bus.req_i = 1'b0;
      wait_done("t6b_done", dc);
      chk("t6b_nbeats", 128'(log_n - base), 128'd8);
      chk("t6b_fill", bus.fill_line_o, exp_line(32'h9000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
